// File: rtl/bp_pkg.sv
// Shared types for branch resolution: queued prediction record and resolver FSM states.
package bp_pkg;

    localparam logic [6:0] BR_OPCODE = 7'b1100011;

    typedef struct packed {
        logic [31:0] pc;
        logic        taken;
        logic [31:0] target;
        logic        sel;
    } pred_entry_t;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } br_state_e;

endpackage

// File: rtl/pred_fifo.sv
// In-flight prediction queue: DEPTH-entry FIFO with synchronous clear, head visible combinationally.
// Latency 1 cycle push-to-head; the caller must only push while not full, or while also popping.
module pred_fifo
    import bp_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_clr,
    input  logic        i_push,
    input  logic        i_pop,
    input  pred_entry_t i_wdat,
    output pred_entry_t o_rdat,
    output logic        o_full,
    output logic        o_empty,
    output logic [AW:0] o_count
);

    pred_entry_t   r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (i_clr) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) r_wptr <= r_wptr + 1'b1;
            if (i_pop)  r_rptr <= r_rptr + 1'b1;
            r_count <= r_count + (AW+1)'(i_push) - (AW+1)'(i_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (i_push && !i_clr) r_mem[r_wptr] <= i_wdat;
    end

    assign o_rdat  = r_mem[r_rptr];
    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule

// File: rtl/branch_resolve.sv
// Resolves queued IF predictions against EX outcomes; drives predictor update, flush and redirect.
// Update/redirect 1 cycle after ex_valid; pred_ready is registered and drops while full or flushing.
module branch_resolve
    import bp_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pred_valid,
    output logic        pred_ready,
    input  logic [31:0] pred_pc,
    input  logic        pred_taken,
    input  logic [31:0] pred_target,
    input  logic        pred_sel,
    input  logic        ex_valid,
    input  logic [31:0] ex_pc,
    input  logic        ex_taken,
    input  logic [31:0] ex_target,
    output logic        upd_valid,
    output logic        upd_taken,
    output logic        upd_correct,
    output logic        upd_sel,
    output logic [31:0] upd_pc,
    output logic        flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        seq_error,
    output logic [31:0] br_count,
    output logic [31:0] mis_count
);

    localparam int AW  = $clog2(DEPTH);
    localparam int FCW = $clog2(FLUSH_CYCLES + 1);

    pred_entry_t    w_wdat;
    pred_entry_t    w_head;
    logic           w_full;
    logic           w_empty;
    logic [AW:0]    w_count;
    logic [AW:0]    w_cnt_nxt;

    br_state_e      r_state;
    br_state_e      w_state_nxt;
    logic [FCW-1:0] r_fcnt;
    logic [FCW-1:0] w_fcnt_nxt;

    logic           w_run;
    logic           w_resolve;
    logic           w_head_ok;
    logic           w_correct;
    logic           w_mispred;
    logic           w_push;
    logic           w_pop;
    logic [31:0]    w_br_nxt;
    logic [31:0]    w_mis_nxt;

    logic           r_ready;
    logic           r_upd_valid;
    logic           r_upd_taken;
    logic           r_upd_correct;
    logic           r_upd_sel;
    logic [31:0]    r_upd_pc;
    logic           r_redir_valid;
    logic [31:0]    r_redir_pc;
    logic           r_seq_error;
    logic [31:0]    r_br_count;
    logic [31:0]    r_mis_count;

    assign w_wdat = '{pc: pred_pc, taken: pred_taken, target: pred_target, sel: pred_sel};

    pred_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clr   (w_mispred),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdat  (w_wdat),
        .o_rdat  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // A push into a full queue is accepted when the head pops the same cycle, keeping it full.
    always_comb begin
        w_run     = (r_state == RUN);
        w_resolve = ex_valid && w_run;
        w_head_ok = !w_empty && (w_head.pc == ex_pc);
        w_correct = w_head_ok && (w_head.taken == ex_taken) &&
                    (!ex_taken || (w_head.target == ex_target));
        w_mispred = w_resolve && !w_correct;
        w_pop     = w_resolve && !w_empty && !w_mispred;
        w_push    = pred_valid && w_run && !w_mispred && (!w_full || w_pop);
        w_cnt_nxt = w_mispred ? '0 : (w_count + (AW+1)'(w_push) - (AW+1)'(w_pop));
        w_br_nxt  = (w_resolve && (r_br_count != '1)) ? r_br_count + 32'd1 : r_br_count;
        w_mis_nxt = (w_mispred && (r_mis_count != '1)) ? r_mis_count + 32'd1 : r_mis_count;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_fcnt_nxt  = r_fcnt;
        case (r_state)
            RUN: begin
                if (w_mispred) begin
                    w_state_nxt = FLUSH;
                    w_fcnt_nxt  = '0;
                end
            end
            FLUSH: begin
                if (r_fcnt == FCW'(FLUSH_CYCLES - 1)) w_state_nxt = RUN;
                else                                  w_fcnt_nxt  = r_fcnt + 1'b1;
            end
            default: w_state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= RUN;
            r_fcnt        <= '0;
            r_ready       <= 1'b0;
            r_upd_valid   <= 1'b0;
            r_upd_taken   <= 1'b0;
            r_upd_correct <= 1'b0;
            r_upd_sel     <= 1'b0;
            r_upd_pc      <= '0;
            r_redir_valid <= 1'b0;
            r_redir_pc    <= '0;
            r_seq_error   <= 1'b0;
            r_br_count    <= '0;
            r_mis_count   <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_fcnt        <= w_fcnt_nxt;
            r_ready       <= (w_state_nxt == RUN) && (w_cnt_nxt != (AW+1)'(DEPTH));
            r_upd_valid   <= w_resolve;
            r_redir_valid <= w_mispred;
            r_br_count    <= w_br_nxt;
            r_mis_count   <= w_mis_nxt;
            if (w_resolve) begin
                r_upd_taken   <= ex_taken;
                r_upd_correct <= w_correct;
                r_upd_sel     <= w_head_ok ? w_head.sel : 1'b0;
                r_upd_pc      <= ex_pc;
                if (!w_head_ok) r_seq_error <= 1'b1;
            end
            if (w_mispred) r_redir_pc <= ex_taken ? ex_target : ex_pc + 32'd4;
        end
    end

    assign pred_ready     = r_ready;
    assign flush          = (r_state == FLUSH);
    assign upd_valid      = r_upd_valid;
    assign upd_taken      = r_upd_taken;
    assign upd_correct    = r_upd_correct;
    assign upd_sel        = r_upd_sel;
    assign upd_pc         = r_upd_pc;
    assign redirect_valid = r_redir_valid;
    assign redirect_pc    = r_redir_pc;
    assign seq_error      = r_seq_error;
    assign br_count       = r_br_count;
    assign mis_count      = r_mis_count;

endmodule

// File: tb/tb_branch_resolve.sv
// Directed bench for branch_resolve: stimulus queues expected updates/redirects, a negedge monitor checks them.
module tb_branch_resolve;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pred_valid = 1'b0;
    logic        pred_ready;
    logic [31:0] pred_pc = '0;
    logic        pred_taken = 1'b0;
    logic [31:0] pred_target = '0;
    logic        pred_sel = 1'b0;
    logic        ex_valid = 1'b0;
    logic [31:0] ex_pc = '0;
    logic        ex_taken = 1'b0;
    logic [31:0] ex_target = '0;
    logic        upd_valid, upd_taken, upd_correct, upd_sel;
    logic [31:0] upd_pc;
    logic        flush, redirect_valid, seq_error;
    logic [31:0] redirect_pc, br_count, mis_count;

    int n_checks = 0;
    int n_errors = 0;

    logic [34:0] exp_upd_q[$];
    logic [31:0] exp_redir_q[$];

    branch_resolve #(.DEPTH(4), .FLUSH_CYCLES(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .pred_valid(pred_valid), .pred_ready(pred_ready), .pred_pc(pred_pc),
        .pred_taken(pred_taken), .pred_target(pred_target), .pred_sel(pred_sel),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_taken(ex_taken), .ex_target(ex_target),
        .upd_valid(upd_valid), .upd_taken(upd_taken), .upd_correct(upd_correct),
        .upd_sel(upd_sel), .upd_pc(upd_pc), .flush(flush),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .seq_error(seq_error), .br_count(br_count), .mis_count(mis_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every update/redirect strobe must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && upd_valid) begin
            if (exp_upd_q.size() == 0) begin
                n_checks++; n_errors++;
                $display("FAIL upd_unexpected: got pc 0x%0h, expected no update", upd_pc);
            end else begin
                chk("upd{taken,correct,sel,pc}", {upd_taken, upd_correct, upd_sel, upd_pc},
                    exp_upd_q.pop_front());
            end
        end
        if (rst_n && redirect_valid) begin
            if (exp_redir_q.size() == 0) begin
                n_checks++; n_errors++;
                $display("FAIL redirect_unexpected: got 0x%0h, expected no redirect", redirect_pc);
            end else begin
                chk("redirect_pc", redirect_pc, exp_redir_q.pop_front());
            end
        end
    end

    task automatic push(input logic [31:0] pc, input logic tk, input logic [31:0] tgt, input logic sel);
        pred_valid = 1'b1; pred_pc = pc; pred_taken = tk; pred_target = tgt; pred_sel = sel;
        tick();
        pred_valid = 1'b0;
    endtask

    // Expected values are hand-computed and passed in by the caller.
    task automatic resolve(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                           input logic e_corr, input logic e_sel, input logic [31:0] e_rpc);
        ex_valid = 1'b1; ex_pc = pc; ex_taken = tk; ex_target = tgt;
        exp_upd_q.push_back({tk, e_corr, e_sel, pc});
        if (!e_corr) exp_redir_q.push_back(e_rpc);
        tick();
        ex_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pred_ready", pred_ready, 0);
        chk("rst_flush", flush, 0);
        chk("rst_upd_valid", upd_valid, 0);
        chk("rst_redirect_valid", redirect_valid, 0);
        chk("rst_seq_error", seq_error, 0);
        chk("rst_br_count", br_count, 0);
        chk("rst_mis_count", mis_count, 0);
        rst_n = 1'b1;
        tick();
        chk("ready_after_reset", pred_ready, 1);

        // Correct not-taken
        push(32'h100, 1'b0, 32'h104, 1'b1);
        resolve(32'h100, 1'b0, 32'h104, 1'b1, 1'b1, 32'h0);
        chk("t1_flush", flush, 0);
        chk("t1_br_count", br_count, 1);
        chk("t1_mis_count", mis_count, 0);

        // Mispredict with a younger entry and a same-cycle push, both discarded
        push(32'h200, 1'b0, 32'h204, 1'b1);
        push(32'h208, 1'b0, 32'h20C, 1'b0);
        pred_valid = 1'b1; pred_pc = 32'h20C; pred_taken = 1'b0; pred_target = 32'h210;
        resolve(32'h200, 1'b1, 32'h180, 1'b0, 1'b1, 32'h180);
        chk("mp_flush_n1", flush, 1);
        chk("mp_ready_n1", pred_ready, 0);
        chk("mp_mis_count", mis_count, 1);
        chk("mp_br_count", br_count, 2);
        // Activity during FLUSH is ignored
        pred_valid = 1'b1; pred_pc = 32'h2F0;
        ex_valid = 1'b1; ex_pc = 32'h2F0; ex_taken = 1'b1; ex_target = 32'h2F8;
        tick();
        pred_valid = 1'b0; ex_valid = 1'b0;
        chk("mp_flush_n2", flush, 1);
        chk("mp_ready_n2", pred_ready, 0);
        tick();
        chk("mp_flush_n3", flush, 0);
        chk("mp_ready_n3", pred_ready, 1);
        chk("mp_br_count_after_flush", br_count, 2);

        // Full queue, simultaneous push+pop, then pop-only
        push(32'h400, 1'b0, 32'h404, 1'b0);
        push(32'h404, 1'b0, 32'h408, 1'b1);
        push(32'h408, 1'b0, 32'h40C, 1'b0);
        chk("full_ready_after3", pred_ready, 1);
        push(32'h40C, 1'b0, 32'h410, 1'b1);
        chk("full_ready_after4", pred_ready, 0);
        pred_valid = 1'b1; pred_pc = 32'h410; pred_taken = 1'b1; pred_target = 32'h500; pred_sel = 1'b1;
        resolve(32'h400, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        pred_valid = 1'b0;
        chk("full_ready_pushpop", pred_ready, 0);
        resolve(32'h404, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0);
        chk("full_ready_pop_only", pred_ready, 1);
        resolve(32'h408, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        resolve(32'h40C, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0);
        resolve(32'h410, 1'b1, 32'h500, 1'b1, 1'b1, 32'h0);
        chk("full_br_count", br_count, 7);
        chk("full_mis_count", mis_count, 1);

        // Not-taken mispredict at the top of the address space wraps the redirect
        push(32'hFFFF_FFFC, 1'b1, 32'h0000_1000, 1'b1);
        resolve(32'hFFFF_FFFC, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0000);
        tick();
        tick();
        chk("wrap_mis_count", mis_count, 2);
        chk("wrap_ready", pred_ready, 1);

        // Saturation of br_count
        force dut.r_br_count = 32'hFFFF_FFFF;
        push(32'h500, 1'b0, 32'h504, 1'b0);
        release dut.r_br_count;
        chk("sat_br_preset", br_count, 32'hFFFF_FFFF);
        resolve(32'h500, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        chk("sat_br_hold", br_count, 32'hFFFF_FFFF);
        chk("sat_mis_count", mis_count, 2);
        chk("sat_seq_error_clear", seq_error, 0);

        // Head PC mismatch
        push(32'h304, 1'b0, 32'h308, 1'b1);
        resolve(32'h300, 1'b0, 32'h0, 1'b0, 1'b0, 32'h304);
        chk("seq_error_mismatch", seq_error, 1);
        chk("seq_flush", flush, 1);
        tick();
        tick();
        // Resolution on an empty queue
        resolve(32'h600, 1'b1, 32'h700, 1'b0, 1'b0, 32'h700);
        chk("seq_error_sticky", seq_error, 1);
        chk("seq_mis_count", mis_count, 4);
        tick();
        chk("rstflush_flush_before", flush, 1);

        // Reset during FLUSH
        rst_n = 1'b0;
        #1;
        chk("rstflush_flush", flush, 0);
        chk("rstflush_seq_error", seq_error, 0);
        chk("rstflush_br_count", br_count, 0);
        chk("rstflush_mis_count", mis_count, 0);
        #3;
        rst_n = 1'b1;
        tick();
        chk("rstflush_ready", pred_ready, 1);
        push(32'h800, 1'b0, 32'h804, 1'b0);
        push(32'h804, 1'b0, 32'h808, 1'b0);
        push(32'h808, 1'b0, 32'h80C, 1'b0);
        chk("rstflush_empty_after3", pred_ready, 1);
        push(32'h80C, 1'b0, 32'h810, 1'b0);
        chk("rstflush_full_after4", pred_ready, 0);

        repeat (3) tick();
        chk("pending_updates", exp_upd_q.size(), 0);
        chk("pending_redirects", exp_redir_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
